// File: rtl/ppu_pkg.sv
// Shared types and constants for the PPU pipeline front end.
package ppu_pkg;

  localparam int unsigned XLEN        = 32;
  localparam int unsigned WORD_BYTES  = 4;
  localparam int unsigned FLUSH_CNT_W = 2;
  localparam int unsigned COUNT_W     = 16;

  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    STALL = 2'd2,
    FLUSH = 2'd3
  } fetch_state_e;

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
    logic            valid;
  } if_id_t;

  // Force an address onto a word boundary.
  function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/pc_unit.sv
// Program counter: word-aligned load for redirects, modulo-RAM-size increment for fetches.
module pc_unit
  import ppu_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC  = 32'h0000_0000,
  parameter int unsigned     MEM_BYTES = 256
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            load,
  input  logic            advance,
  input  logic [XLEN-1:0] target,
  output logic [XLEN-1:0] pc
);

  localparam logic [XLEN-1:0] ADDR_MASK = XLEN'(MEM_BYTES - 1);

  logic [XLEN-1:0] pc_next;

  // A redirect takes precedence over a sequential step.
  always_comb begin
    pc_next = pc;
    if (load) begin
      pc_next = align_word(target) & ADDR_MASK;
    end else if (advance) begin
      pc_next = (pc + XLEN'(WORD_BYTES)) & ADDR_MASK;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc <= RESET_PC;
    end else begin
      pc <= pc_next;
    end
  end

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction-fetch controller: sequences the PC through stalls and taken-branch
// flushes and loads the IF/ID pipeline register from the instruction RAM.
module fetch_sequencer
  import ppu_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC     = 32'h0000_0000,
  parameter int unsigned     MEM_BYTES    = 256,
  parameter int unsigned     FLUSH_CYCLES = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               stall_in,
  input  logic               branch_taken,
  input  logic [XLEN-1:0]    branch_target,
  input  logic [XLEN-1:0]    ram_data,
  output logic [XLEN-1:0]    ram_addr,
  output logic               ram_enable,
  output logic [XLEN-1:0]    if_id_instr,
  output logic [XLEN-1:0]    if_id_pc,
  output logic               if_id_valid,
  output logic               misalign_err,
  output logic [COUNT_W-1:0] fetch_count
);

  fetch_state_e           state, state_nxt;
  logic [FLUSH_CNT_W-1:0] flush_cnt, flush_nxt;
  if_id_t                 if_id, if_id_nxt;
  logic                   misalign_nxt;
  logic [COUNT_W-1:0]     count_nxt;
  logic                   pc_load, pc_advance;
  logic [XLEN-1:0]        pc;

  pc_unit #(
    .RESET_PC  (RESET_PC),
    .MEM_BYTES (MEM_BYTES)
  ) u_pc_unit (
    .clk     (clk),
    .reset   (reset),
    .load    (pc_load),
    .advance (pc_advance),
    .target  (branch_target),
    .pc      (pc)
  );

  // Next-state and datapath control; priority is branch > stall > fetch.
  always_comb begin
    state_nxt    = state;
    flush_nxt    = flush_cnt;
    if_id_nxt    = if_id;
    misalign_nxt = misalign_err;
    count_nxt    = fetch_count;
    pc_load      = 1'b0;
    pc_advance   = 1'b0;

    case (state)
      IDLE: begin
        state_nxt = RUN;
      end
      RUN, STALL: begin
        if (branch_taken) begin
          pc_load   = 1'b1;
          if_id_nxt = '{instr: NOP_INSTR, pc: '0, valid: 1'b0};
          flush_nxt = FLUSH_CNT_W'(FLUSH_CYCLES - 1);
          state_nxt = FLUSH;
          if (branch_target[1:0] != 2'b00) begin
            misalign_nxt = 1'b1;
          end
        end else if (state == STALL) begin
          // Leaving STALL spends one restart cycle before the next fetch.
          if (!stall_in) begin
            state_nxt = RUN;
          end
        end else if (stall_in) begin
          state_nxt = STALL;
        end else begin
          pc_advance = 1'b1;
          if_id_nxt  = '{instr: ram_data, pc: pc, valid: 1'b1};
          count_nxt  = fetch_count + COUNT_W'(1);
        end
      end
      FLUSH: begin
        if (flush_cnt == '0) begin
          state_nxt = RUN;
        end else begin
          flush_nxt = flush_cnt - FLUSH_CNT_W'(1);
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      flush_cnt    <= '0;
      if_id        <= '0;
      misalign_err <= 1'b0;
      fetch_count  <= '0;
    end else begin
      state        <= state_nxt;
      flush_cnt    <= flush_nxt;
      if_id        <= if_id_nxt;
      misalign_err <= misalign_nxt;
      fetch_count  <= count_nxt;
    end
  end

  assign ram_addr    = pc;
  assign ram_enable  = (state == RUN);
  assign if_id_instr = if_id.instr;
  assign if_id_pc    = if_id.pc;
  assign if_id_valid = if_id.valid;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: run, stall, branch flush, misalign, wrap, async reset.
module tb_fetch_sequencer;

  logic        clk;
  logic        reset;
  logic        stall_in;
  logic        branch_taken;
  logic [31:0] branch_target;

  logic [31:0] ram_data, ram_addr, if_id_instr, if_id_pc;
  logic        ram_enable, if_id_valid, misalign_err;
  logic [15:0] fetch_count;

  logic [31:0] ram_data3, ram_addr3, if_id_instr3, if_id_pc3;
  logic        ram_enable3, if_id_valid3, misalign_err3;
  logic [15:0] fetch_count3;

  logic [31:0] rom [64];

  int checks = 0;
  int errors = 0;

  fetch_sequencer #(.RESET_PC(32'h0), .MEM_BYTES(256), .FLUSH_CYCLES(1)) u_dut (
    .clk           (clk),
    .reset         (reset),
    .stall_in      (stall_in),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .ram_data      (ram_data),
    .ram_addr      (ram_addr),
    .ram_enable    (ram_enable),
    .if_id_instr   (if_id_instr),
    .if_id_pc      (if_id_pc),
    .if_id_valid   (if_id_valid),
    .misalign_err  (misalign_err),
    .fetch_count   (fetch_count)
  );

  fetch_sequencer #(.RESET_PC(32'h0), .MEM_BYTES(256), .FLUSH_CYCLES(3)) u_dut3 (
    .clk           (clk),
    .reset         (reset),
    .stall_in      (stall_in),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .ram_data      (ram_data3),
    .ram_addr      (ram_addr3),
    .ram_enable    (ram_enable3),
    .if_id_instr   (if_id_instr3),
    .if_id_pc      (if_id_pc3),
    .if_id_valid   (if_id_valid3),
    .misalign_err  (misalign_err3),
    .fetch_count   (fetch_count3)
  );

  assign ram_data  = rom[ram_addr[7:2]];
  assign ram_data3 = rom[ram_addr3[7:2]];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] word_at(input logic [31:0] addr);
    return 32'hA000_0000 + 32'(addr >> 2);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reset pulse, then the IDLE edge; leaves the DUT in RUN at RESET_PC.
  task automatic do_reset();
    reset = 1'b0;
    stall_in = 1'b0;
    branch_taken = 1'b0;
    branch_target = 32'h0;
    #4;
    reset = 1'b1;
    step();
  endtask

  task automatic test_reset();
    reset = 1'b0;
    stall_in = 1'b0;
    branch_taken = 1'b0;
    branch_target = 32'h0;
    #12;
    checks++;
    if (ram_addr !== 32'h0 || ram_enable !== 1'b0 || if_id_instr !== 32'h0 ||
        if_id_pc !== 32'h0 || if_id_valid !== 1'b0 || misalign_err !== 1'b0 ||
        fetch_count !== 16'h0) begin
      errors++;
      $display("FAIL reset_values addr=%h en=%b instr=%h pc=%h valid=%b mis=%b cnt=%0d expected all zero",
               ram_addr, ram_enable, if_id_instr, if_id_pc, if_id_valid, misalign_err, fetch_count);
    end
    reset = 1'b1;
    step();
    checks++;
    if (if_id_valid !== 1'b0 || ram_enable !== 1'b1 || fetch_count !== 16'd0 || ram_addr !== 32'h0) begin
      errors++;
      $display("FAIL idle_cycle valid=%b en=%b cnt=%0d addr=%h expected 0 1 0 0",
               if_id_valid, ram_enable, fetch_count, ram_addr);
    end
  endtask

  task automatic test_run();
    for (int i = 0; i < 4; i++) begin
      logic [31:0] exp_pc;
      exp_pc = 32'(i * 4);
      step();
      checks++;
      if (if_id_pc !== exp_pc || if_id_instr !== word_at(exp_pc) || if_id_valid !== 1'b1 ||
          fetch_count !== 16'(i + 1)) begin
        errors++;
        $display("FAIL run_fetch%0d pc=%h instr=%h valid=%b cnt=%0d expected pc=%h instr=%h valid=1 cnt=%0d",
                 i, if_id_pc, if_id_instr, if_id_valid, fetch_count, exp_pc, word_at(exp_pc), i + 1);
      end
    end
  endtask

  task automatic test_stall();
    do_reset();
    step();
    step();
    stall_in = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (ram_enable !== 1'b0 || if_id_pc !== 32'h4 || if_id_instr !== word_at(32'h4) ||
          fetch_count !== 16'd2 || ram_addr !== 32'h8) begin
        errors++;
        $display("FAIL stall_hold%0d en=%b if_pc=%h cnt=%0d addr=%h expected en=0 if_pc=4 cnt=2 addr=8",
                 i, ram_enable, if_id_pc, fetch_count, ram_addr);
      end
    end
    stall_in = 1'b0;
    step();
    checks++;
    if (ram_enable !== 1'b1 || if_id_pc !== 32'h4 || fetch_count !== 16'd2) begin
      errors++;
      $display("FAIL stall_restart en=%b if_pc=%h cnt=%0d expected en=1 if_pc=4 cnt=2",
               ram_enable, if_id_pc, fetch_count);
    end
    step();
    checks++;
    if (if_id_pc !== 32'h8 || if_id_instr !== word_at(32'h8) || fetch_count !== 16'd3) begin
      errors++;
      $display("FAIL stall_resume if_pc=%h instr=%h cnt=%0d expected if_pc=8 instr=%h cnt=3",
               if_id_pc, if_id_instr, fetch_count, word_at(32'h8));
    end
  endtask

  task automatic test_branch();
    step();
    branch_taken = 1'b1;
    branch_target = 32'h40;
    step();
    branch_taken = 1'b0;
    checks++;
    if (if_id_instr !== 32'h0 || if_id_valid !== 1'b0 || if_id_pc !== 32'h0 ||
        ram_enable !== 1'b0 || ram_addr !== 32'h40 || fetch_count !== 16'd4) begin
      errors++;
      $display("FAIL branch_flush instr=%h valid=%b if_pc=%h en=%b addr=%h cnt=%0d expected 0 0 0 0 40 4",
               if_id_instr, if_id_valid, if_id_pc, ram_enable, ram_addr, fetch_count);
    end
    step();
    checks++;
    if (if_id_valid !== 1'b0 || ram_enable !== 1'b1) begin
      errors++;
      $display("FAIL branch_rerun valid=%b en=%b expected valid=0 en=1", if_id_valid, ram_enable);
    end
    step();
    checks++;
    if (if_id_pc !== 32'h40 || if_id_instr !== word_at(32'h40) || if_id_valid !== 1'b1 ||
        fetch_count !== 16'd5) begin
      errors++;
      $display("FAIL branch_target_fetch if_pc=%h instr=%h valid=%b cnt=%0d expected 40 %h 1 5",
               if_id_pc, if_id_instr, if_id_valid, fetch_count, word_at(32'h40));
    end
  endtask

  task automatic test_branch_stall();
    branch_taken = 1'b1;
    stall_in = 1'b1;
    branch_target = 32'h22;
    step();
    branch_taken = 1'b0;
    checks++;
    if (ram_addr !== 32'h20 || misalign_err !== 1'b1 || ram_enable !== 1'b0 || if_id_valid !== 1'b0) begin
      errors++;
      $display("FAIL branch_stall addr=%h mis=%b en=%b valid=%b expected addr=20 mis=1 en=0 valid=0",
               ram_addr, misalign_err, ram_enable, if_id_valid);
    end
    step();
    checks++;
    if (ram_enable !== 1'b1 || misalign_err !== 1'b1) begin
      errors++;
      $display("FAIL flush_ignores_stall en=%b mis=%b expected en=1 mis=1", ram_enable, misalign_err);
    end
    stall_in = 1'b0;
    step();
    checks++;
    if (if_id_pc !== 32'h20 || if_id_instr !== word_at(32'h20) || misalign_err !== 1'b1 ||
        fetch_count !== 16'd6) begin
      errors++;
      $display("FAIL misalign_sticky if_pc=%h instr=%h mis=%b cnt=%0d expected 20 %h 1 6",
               if_id_pc, if_id_instr, misalign_err, fetch_count, word_at(32'h20));
    end
  endtask

  task automatic test_wrap();
    logic [31:0] exp_pc [3];
    exp_pc[0] = 32'hF8;
    exp_pc[1] = 32'hFC;
    exp_pc[2] = 32'h0;
    branch_taken = 1'b1;
    branch_target = 32'hF8;
    step();
    branch_target = 32'h80;
    step();
    branch_taken = 1'b0;
    checks++;
    if (ram_addr !== 32'hF8 || ram_enable !== 1'b1) begin
      errors++;
      $display("FAIL flush_ignores_branch addr=%h en=%b expected addr=f8 en=1", ram_addr, ram_enable);
    end
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (if_id_pc !== exp_pc[i] || if_id_instr !== word_at(exp_pc[i]) || fetch_count !== 16'(7 + i)) begin
        errors++;
        $display("FAIL wrap_fetch%0d if_pc=%h instr=%h cnt=%0d expected %h %h %0d",
                 i, if_id_pc, if_id_instr, fetch_count, exp_pc[i], word_at(exp_pc[i]), 7 + i);
      end
    end
    checks++;
    if (ram_addr !== 32'h4) begin
      errors++;
      $display("FAIL wrap_addr addr=%h expected 4", ram_addr);
    end
  endtask

  task automatic test_reset_mid_flush();
    do_reset();
    step();
    branch_taken = 1'b1;
    branch_target = 32'h11;
    step();
    branch_taken = 1'b0;
    step();
    checks++;
    if (ram_enable3 !== 1'b0 || misalign_err3 !== 1'b1 || ram_addr3 !== 32'h10 ||
        fetch_count3 !== 16'd1 || if_id_valid3 !== 1'b0) begin
      errors++;
      $display("FAIL flush3_second_cycle en=%b mis=%b addr=%h cnt=%0d valid=%b expected 0 1 10 1 0",
               ram_enable3, misalign_err3, ram_addr3, fetch_count3, if_id_valid3);
    end
    reset = 1'b0;
    #1;
    checks++;
    if (ram_addr3 !== 32'h0 || ram_enable3 !== 1'b0 || if_id_instr3 !== 32'h0 ||
        if_id_pc3 !== 32'h0 || if_id_valid3 !== 1'b0 || misalign_err3 !== 1'b0 ||
        fetch_count3 !== 16'h0) begin
      errors++;
      $display("FAIL async_reset addr=%h en=%b instr=%h pc=%h valid=%b mis=%b cnt=%0d expected all zero",
               ram_addr3, ram_enable3, if_id_instr3, if_id_pc3, if_id_valid3, misalign_err3, fetch_count3);
    end
    #4;
    reset = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < 64; i++) begin
      rom[i] = 32'hA000_0000 + 32'(i);
    end
    test_reset();
    test_run();
    test_stall();
    test_branch();
    test_branch_stall();
    test_wrap();
    test_reset_mid_flush();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
Instruction-fetch controller for the PPU pipeline front end. Drives the byte-addressed instruction RAM (256x8, 4-byte words, address steps of 4) and loads the IF/ID pipeline register. Sequences the program counter through stalls from the hazard unit and redirects from the condition handler's branch-taken signal. Inserts NOPs (32'h0) on every flush.

Parameters:
RESET_PC, 32'h0000_0000, PC value after reset; must be word-aligned.
MEM_BYTES, 256, instruction RAM size in bytes; PC wraps modulo this value; must be a power of 2.
FLUSH_CYCLES, 1, number of bubble cycles after a taken branch; legal range 1..3.

Ports:
clk  in  1  pipeline clock; all state updates on the rising edge
reset  in  1  asynchronous, active-low reset
stall_in  in  1  hazard-unit stall request; level-sensitive
branch_taken  in  1  taken-branch redirect from the condition handler (choose_ta_r_nop)
branch_target  in  32  redirect target address
ram_data  in  32  instruction word from the RAM; combinational read
ram_addr  out  32  RAM address; always equals pc
ram_enable  out  1  RAM read enable
if_id_instr  out  32  IF/ID instruction register
if_id_pc  out  32  IF/ID PC register
if_id_valid  out  1  IF/ID slot holds a real instruction
misalign_err  out  1  sticky flag: a branch target had bits [1:0] != 0
fetch_count  out  16  number of completed fetches; wraps at 16'hFFFF

Behaviour:
- Reset (asynchronous, while reset=0):
  - pc=RESET_PC; state=IDLE; flush_cnt=0.
  - if_id_instr=0, if_id_pc=0, if_id_valid=0, misalign_err=0, fetch_count=0.
- ram_addr=pc, combinationally. ram_enable=1 only when state=RUN.
- States: IDLE, RUN, STALL, FLUSH. Edge priority: reset > branch_taken > stall_in > normal operation.
- IDLE: lasts exactly one cycle after reset release. branch_taken and stall_in are ignored. Next state is RUN.
- RUN, normal edge (no branch, no stall):
  - if_id_instr<=ram_data; if_id_pc<=pc; if_id_valid<=1.
  - pc<=(pc+4) mod MEM_BYTES; fetch_count++.
- RUN, edge with stall_in=1 and no branch: pc, IF/ID and fetch_count hold. Next state is STALL.
- STALL: everything holds.
  - stall_in=0 at an edge: next state is RUN. No fetch happens on that edge; fetch resumes on the following edge (one restart cycle).
- Taken branch, edge in RUN or STALL with branch_taken=1:
  - pc<={branch_target[31:2],2'b00} mod MEM_BYTES.
  - if_id_instr<=32'h0; if_id_valid<=0; if_id_pc<=0.
  - flush_cnt<=FLUSH_CYCLES-1; next state is FLUSH.
  - If branch_target[1:0]!=0, misalign_err<=1. It stays set until reset.
- FLUSH:
  - IF/ID holds the NOP; ram_enable=0; branch_taken and stall_in are ignored.
  - If flush_cnt=0, next state is RUN; otherwise flush_cnt--.
- Wrap: with MEM_BYTES=256, pc=252 fetches and then pc=0.
- Branch and stall on the same edge: the branch wins and the stall is dropped.
- Reset mid-flush or mid-stall: immediate return to the reset values; no partial update survives.

Decomposition:
- Shared package ppu_pkg:
  - state encoding (IDLE=2'd0, RUN=2'd1, STALL=2'd2, FLUSH=2'd3);
  - NOP_INSTR=32'h0;
  - WORD_BYTES=4.
- One natural sub-module: pc_unit (PC register with alignment, modulo increment and load). The FSM, flush counter and IF/ID register stay at the top level.

Test Plan:
- Reset then run 4 cycles, RAM preloaded with words W0..W3 at byte addresses 0,4,8,12 -> if_id_pc goes 0,4,8,12 with matching instructions; fetch_count=4; the first fetch occurs on the 2nd edge after reset release (IDLE cycle).
- stall_in=1 for 3 cycles starting with pc=8 -> ram_enable=0 and IF/ID frozen at pc=4; after stall drops, 1 restart cycle, then if_id_pc=8 on the next edge.
- branch_taken=1, branch_target=32'h40 at pc=16 with FLUSH_CYCLES=1 -> if_id_instr=0 and if_id_valid=0 for 1 cycle, then if_id_pc=0x40.
- branch_taken=1 and stall_in=1 on the same edge, branch_target=32'h22 -> pc=0x20; misalign_err=1 and stays 1; state FLUSH, not STALL.
- Start at pc=248, run 3 fetches -> if_id_pc goes 248, 252, 0; branch_taken asserted during FLUSH is ignored.
- Assert reset low mid-FLUSH (FLUSH_CYCLES=3, second cycle) -> all outputs return to their reset values immediately, without waiting for a clock edge.
